// File: rtl/mem_arbiter.sv
// Arbiter that serialises IF-stage fetches and MEM-stage loads/stores onto one
// variable-latency memory port. Optional fetch buffer enabled by MEM_ARB_IBUF_EN.
module mem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          if_req_i,
    input  logic [AW-1:0] if_addr_i,
    input  logic          d_rd_i,
    input  logic          d_wr_i,
    input  logic [AW-1:0] d_addr_i,
    input  logic [DW-1:0] d_wdata_i,
    output logic [DW-1:0] if_inst_o,
    output logic [DW-1:0] d_rdata_o,
    output logic          stall_o,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic          mem_ack_i,
    input  logic [DW-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        D_BUSY = 2'd1,
        I_BUSY = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic d_done;
    logic i_done;
    logic d_req;
    logic d_pend;
    logic i_pend;
    logic ibuf_hit;
    logic issue_d;
    logic issue_i;
    logic clear_done;
    logic d_ack;
    logic i_ack;

    assign d_req  = d_rd_i | d_wr_i;
    assign d_pend = d_req & ~d_done;
    assign d_ack  = (state == D_BUSY) & mem_ack_i;
    assign i_ack  = (state == I_BUSY) & mem_ack_i;

`ifdef MEM_ARB_IBUF_EN
    logic [AW-1:0] ibuf_tag;
    logic          ibuf_valid;

    // A hit resolves the fetch combinationally; if_inst_o still holds that word.
    assign ibuf_hit = ibuf_valid & (ibuf_tag == if_addr_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ibuf_tag   <= '0;
            ibuf_valid <= 1'b0;
        end else if (issue_d && d_wr_i && (d_addr_i == ibuf_tag)) begin
            ibuf_valid <= 1'b0;
        end else if (i_ack) begin
            ibuf_tag   <= mem_addr_o;
            ibuf_valid <= 1'b1;
        end
    end
`else
    assign ibuf_hit = 1'b0;
`endif

    assign i_pend    = if_req_i & ~i_done & ~ibuf_hit;
    assign stall_o   = d_pend | i_pend;
    assign mem_req_o = (state != IDLE);

    always_comb begin
        state_nxt  = state;
        issue_d    = 1'b0;
        issue_i    = 1'b0;
        clear_done = 1'b0;
        case (state)
            IDLE: begin
                // Data first: it belongs to the older instruction.
                if (d_pend) begin
                    issue_d   = 1'b1;
                    state_nxt = D_BUSY;
                end else if (i_pend) begin
                    issue_i   = 1'b1;
                    state_nxt = I_BUSY;
                end else begin
                    clear_done = 1'b1;
                end
            end
            D_BUSY: begin
                if (mem_ack_i) state_nxt = IDLE;
            end
            I_BUSY: begin
                if (mem_ack_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    // Completion flags live for one pipeline cycle; cleared on the advancing edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            d_done <= 1'b0;
            i_done <= 1'b0;
        end else if (clear_done) begin
            d_done <= 1'b0;
            i_done <= 1'b0;
        end else begin
            if (d_ack) d_done <= 1'b1;
            if (i_ack) i_done <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_addr_o  <= '0;
            mem_we_o    <= 1'b0;
            mem_wdata_o <= '0;
        end else if (issue_d) begin
            mem_addr_o  <= d_addr_i;
            mem_we_o    <= d_wr_i;
            mem_wdata_o <= d_wdata_i;
        end else if (issue_i) begin
            mem_addr_o <= if_addr_i;
            mem_we_o   <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            if_inst_o <= '0;
            d_rdata_o <= '0;
        end else begin
            if (d_ack && !mem_we_o) d_rdata_o <= mem_rdata_i;
            if (i_ack)              if_inst_o <= mem_rdata_i;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised bench for mem_arbiter: latency-programmable memory responder plus a
// transaction-level reference model of access order, stall length and returned data.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          d_rd;
    logic          d_wr;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] if_inst;
    logic [DW-1:0] d_rdata;
    logic          stall;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(if_req), .if_addr_i(if_addr),
        .d_rd_i(d_rd), .d_wr_i(d_wr), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .if_inst_o(if_inst), .d_rdata_o(d_rdata), .stall_o(stall),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } acc_t;

    acc_t        log_q[$];
    int          lat_q[$];
    logic [31:0] mem     [32];
    logic [31:0] ref_mem [32];
    logic [31:0] exp_inst;
    logic [31:0] exp_rdata;
    bit          spur;
    int          n_vec;
    int          n_err;
`ifdef MEM_ARB_IBUF_EN
    logic [31:0] ib_tag;
    bit          ib_valid;
`endif

    function automatic int widx(input logic [31:0] a);
        return int'(a[6:2]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory responder: acks after the queued number of wait cycles.
    initial begin : responder
        int cnt;
        int lat;
        bit active;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        active    = 1'b0;
        cnt       = 0;
        lat       = 0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            if (rst) begin
                active = 1'b0;
            end else if (mem_req) begin
                if (!active) begin
                    active = 1'b1;
                    cnt    = 0;
                    lat    = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
                end
                if (cnt == lat) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem[widx(mem_addr)];
                    if (mem_we) mem[widx(mem_addr)] = mem_wdata;
                    log_q.push_back('{addr: mem_addr, we: mem_we, wdata: mem_wdata});
                    active = 1'b0;
                end else begin
                    cnt++;
                end
            end else if (spur) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'hBAD0BAD0;
            end
        end
    end

    task automatic run_txn(input bit f, input logic [31:0] fa, input bit rd, input bit wr,
                           input logic [31:0] da, input logic [31:0] wd,
                           input int lat_d, input int lat_i);
        acc_t exp_q[$];
        int   exp_stall;
        int   nst;
        bit   fmem;
        exp_stall = 0;
        nst       = 0;
        if (rd || wr) begin
            lat_q.push_back(lat_d);
            exp_stall += 2 + lat_d;
            exp_q.push_back('{addr: da, we: wr, wdata: wd});
            if (wr) begin
                ref_mem[widx(da)] = wd;
`ifdef MEM_ARB_IBUF_EN
                if (ib_valid && ib_tag == da) ib_valid = 1'b0;
`endif
            end else begin
                exp_rdata = ref_mem[widx(da)];
            end
        end
        if (f) begin
            fmem = 1'b1;
`ifdef MEM_ARB_IBUF_EN
            if (ib_valid && ib_tag == fa) fmem = 1'b0;
`endif
            if (fmem) begin
                lat_q.push_back(lat_i);
                exp_stall += 2 + lat_i;
                exp_q.push_back('{addr: fa, we: 1'b0, wdata: 32'h0});
                exp_inst = ref_mem[widx(fa)];
`ifdef MEM_ARB_IBUF_EN
                ib_tag   = fa;
                ib_valid = 1'b1;
`endif
            end
        end

        if_req = f; if_addr = fa; d_rd = rd; d_wr = wr; d_addr = da; d_wdata = wd;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (!stall) break;
            nst++;
            @(posedge clk);
            #2;
        end
        chk("stall_release", 32'(stall), 32'h0);
        chk("stall_cycles", 32'(nst), 32'(exp_stall));
        chk("req_after", 32'(mem_req), 32'h0);
        chk("n_access", 32'(log_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            chk("acc_addr", log_q[i].addr, exp_q[i].addr);
            chk("acc_we", 32'(log_q[i].we), 32'(exp_q[i].we));
            if (exp_q[i].we) chk("acc_wdata", log_q[i].wdata, exp_q[i].wdata);
        end
        chk("if_inst", if_inst, exp_inst);
        chk("d_rdata", d_rdata, exp_rdata);
        log_q.delete();
        lat_q.delete();
        @(posedge clk);
        #2;
        if_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
    endtask

    initial begin
        n_vec = 0; n_err = 0; spur = 1'b0;
        rst = 1'b1;
        if_req = 1'b0; if_addr = '0; d_rd = 1'b0; d_wr = 1'b0; d_addr = '0; d_wdata = '0;
        for (int i = 0; i < 32; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[0] = 32'h8C220004; ref_mem[0] = 32'h8C220004;
        exp_inst = '0; exp_rdata = '0;
`ifdef MEM_ARB_IBUF_EN
        ib_tag = '0; ib_valid = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #2;
        chk("rst_req", 32'(mem_req), 32'h0);
        chk("rst_we", 32'(mem_we), 32'h0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_inst", if_inst, 32'h0);
        chk("rst_rdata", d_rdata, 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #2;

        run_txn(1, 32'h00, 0, 0, 32'h0, 32'h0, 0, 0);
        run_txn(1, 32'h08, 1, 0, 32'h40, 32'h0, 2, 2);
        run_txn(0, 32'h00, 0, 1, 32'h44, 32'hDEADBEEF, 0, 0);
        run_txn(1, 32'h10, 0, 0, 32'h0, 32'h0, 0, 0);
        run_txn(1, 32'h10, 0, 0, 32'h0, 32'h0, 0, 0);
        run_txn(0, 32'h00, 0, 1, 32'h10, 32'h12345678, 1, 0);
        run_txn(1, 32'h10, 0, 0, 32'h0, 32'h0, 0, 1);
        run_txn(1, 32'h14, 1, 1, 32'h14, 32'hCAFEF00D, 1, 0);

        // Stray ack while idle must be ignored.
        spur = 1'b1;
        @(posedge clk);
        #2;
        spur = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("spur_inst", if_inst, exp_inst);
        chk("spur_rdata", d_rdata, exp_rdata);
        chk("spur_req", 32'(mem_req), 32'h0);
        chk("spur_stall", 32'(stall), 32'h0);

        // Reset in the middle of a load.
        d_rd = 1'b1; d_addr = 32'h20;
        lat_q.push_back(6);
        @(posedge clk);
        #2;
        @(posedge clk);
        #2;
        chk("busy_req", 32'(mem_req), 32'h1);
        #1 rst = 1'b1;
        #1;
        chk("async_req", 32'(mem_req), 32'h0);
        chk("async_addr", mem_addr, 32'h0);
        chk("async_inst", if_inst, 32'h0);
        chk("async_rdata", d_rdata, 32'h0);
        d_rd = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        exp_inst = '0; exp_rdata = '0;
`ifdef MEM_ARB_IBUF_EN
        ib_valid = 1'b0;
`endif
        @(posedge clk);
        #2;
        log_q.delete();
        lat_q.delete();
        chk("post_rst_req", 32'(mem_req), 32'h0);
        chk("post_rst_stall", 32'(stall), 32'h0);
        chk("post_rst_we", 32'(mem_we), 32'h0);

        for (int t = 0; t < 150; t++) begin
            bit          f;
            bit          rd;
            bit          wr;
            logic [31:0] fa;
            logic [31:0] da;
            logic [31:0] op;
            f  = ($urandom_range(0, 3) != 0);
            fa = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 3)) << 2
                                              : 32'($urandom_range(0, 31)) << 2;
            op = 32'($urandom_range(0, 3));
            rd = op[0];
            wr = op[1];
            da = ($urandom_range(0, 2) == 0) ? fa : 32'($urandom_range(0, 31)) << 2;
            run_txn(f, fa, rd, wr, da, $urandom, int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
